// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its downstream
// sprite/overlay consumers; pix_ce flows into the generator, everything else out.
interface vga_timing_gen_if;
   logic       pix_ce;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       hsync;
   logic       vsync;
   logic       blank;
   logic       line_start;
   logic       frame_start;
   logic [7:0] frame_count;

   modport master (
      input  pix_ce,
      output DrawX, DrawY, hsync, vsync, blank, line_start, frame_start, frame_count
   );

   modport slave (
      output pix_ce,
      input  DrawX, DrawY, hsync, vsync, blank, line_start, frame_start, frame_count
   );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: coordinates, active-low syncs, blank and frame/line
// markers, all registered from next-state counters so they stay mutually aligned.
module vga_timing_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic             vga_clk,
   input  logic             reset,
   vga_timing_gen_if.master vga
);

   localparam int         H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int         V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       blank_q, blank_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;
   logic [7:0] frame_count_q, frame_count_d;

   // Next counter position, then syncs/blank derived from that same position so
   // they land in the register together with the coordinates.
   always_comb begin
      h_d           = h_q;
      v_d           = v_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      frame_count_d = frame_count_q;
      if (vga.pix_ce) begin
         if (h_q == H_LAST) begin
            h_d          = 10'd0;
            line_start_d = 1'b1;
            if (v_q == V_LAST) begin
               v_d           = 10'd0;
               frame_start_d = 1'b1;
               frame_count_d = frame_count_q + 8'd1;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
      end else begin
         h_d = h_q;
      end
      hsync_d = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
      vsync_d = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
      blank_d = (h_d >= H_VIS) || (v_d >= V_VIS);
   end

   // Timing state register; reset overrides pix_ce.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         h_q           <= 10'd0;
         v_q           <= 10'd0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         blank_q       <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 8'd0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         blank_q       <= blank_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
      end
   end

   assign vga.DrawX       = h_q;
   assign vga.DrawY       = v_q;
   assign vga.hsync       = hsync_q;
   assign vga.vsync       = vsync_q;
   assign vga.blank       = blank_q;
   assign vga.line_start  = line_start_q;
   assign vga.frame_start = frame_start_q;
   assign vga.frame_count = frame_count_q;

endmodule
